// File: rtl/dmem_arbiter.sv
`default_nettype none
// ==========================================================================
// dmem_arbiter: round-robin 2-port arbiter for a fixed-latency data memory
// Revision: 1.0
// ==========================================================================
module dmem_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic          p0_err,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic          p1_err,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          gnt_id
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);
  localparam bit         HAS_WAIT = (MEM_LAT > 1);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          any_req;
  logic          sel;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          resp;
  logic          rd_ok;

  // Contention goes to the port that did not win last time.
  always_comb begin
    any_req   = p0_req | p1_req;
    sel       = (p0_req & p1_req) ? ~last_q : p1_req;
    sel_we    = sel ? p1_we    : p0_we;
    sel_addr  = sel ? p1_addr  : p0_addr;
    sel_wdata = sel ? p1_wdata : p0_wdata;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          gnt_d   = sel;
          last_d  = sel;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          if (sel_addr[1:0] == 2'b00) begin
            err_d   = 1'b0;
            state_d = S_ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = LAT_LOAD;
        state_d = HAS_WAIT ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // A misaligned read never reached memory, so it returns zero data.
  always_comb begin
    resp      = (state_q == S_RESP);
    rd_ok     = resp & ~we_q & ~err_q;
    p0_ack    = resp & ~gnt_q;
    p1_ack    = resp & gnt_q;
    p0_err    = p0_ack & err_q;
    p1_err    = p1_ack & err_q;
    p0_rdata  = (rd_ok & ~gnt_q) ? mem_rdata : '0;
    p1_rdata  = (rd_ok & gnt_q)  ? mem_rdata : '0;
    mem_en    = (state_q == S_ISSUE);
    mem_we    = we_q & ((state_q == S_ISSUE) | (state_q == S_WAIT));
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    busy      = (state_q != S_IDLE);
    gnt_id    = gnt_q;
  end

endmodule
`default_nettype wire
